// File: rtl/cond_pkg.sv
// Condition codes, status bit positions and lane bounds shared by
// the condition gate and its evaluator.
package cond_pkg;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int FZ = 3;
  localparam int FC = 2;
  localparam int FN = 1;
  localparam int FV = 0;

  localparam int LANES_MIN = 1;
  localparam int LANES_MAX = 4;

  // AL and NV never read the flags, so they never wait on them
  function automatic logic cc_flagless(
    input logic [3:0] cc
  );
    return (cc == CC_AL) || (cc == CC_NV);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of one 4-bit condition against
// the {Z,C,N,V} flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic w_z;
  logic w_c;
  logic w_n;
  logic w_v;

  assign w_z = flags[FZ];
  assign w_c = flags[FC];
  assign w_n = flags[FN];
  assign w_v = flags[FV];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      CC_EQ: cond_true = w_z;
      CC_NE: cond_true = !w_z;
      CC_CS: cond_true = w_c;
      CC_CC: cond_true = !w_c;
      CC_MI: cond_true = w_n;
      CC_PL: cond_true = !w_n;
      CC_VS: cond_true = w_v;
      CC_VC: cond_true = !w_v;
      CC_HI: cond_true = w_c & !w_z;
      CC_LS: cond_true = !w_c | w_z;
      CC_GE: cond_true = (w_n == w_v);
      CC_LT: cond_true = (w_n != w_v);
      CC_GT: cond_true = !w_z & (w_n == w_v);
      CC_LE: cond_true = w_z | (w_n != w_v);
      CC_AL: cond_true = 1'b1;
      CC_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_gate.sv
// Multi-lane condition gate: NZCV status, flag-hazard scoreboard
// and a registered valid/ready output stage.
module cond_issue_gate
  import cond_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int PEND_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               flag_wr,
  input  logic [3:0]         flag_wr_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   in_lane_valid,
  input  logic [4*LANES-1:0] in_cond,
  input  logic [LANES-1:0]   in_s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_exec,
  output logic [LANES-1:0]   out_replay,
  output logic [3:0]         out_status
);

  logic [3:0]       r_status;
  logic [2:0]       r_pend;
  logic             r_out_valid;
  logic [LANES-1:0] r_exec;
  logic [LANES-1:0] r_replay;

  logic [3:0]       w_flags;
  logic [2:0]       w_peff;
  logic [LANES-1:0] w_true;
  logic [LANES-1:0] w_exec;
  logic [LANES-1:0] w_replay;
  logic [3:0]       w_snew;
  logic [3:0]       w_sum;
  logic             w_seen;
  logic             w_hazard;
  logic             w_room;
  logic             w_accept;
  logic [2:0]       w_pnext;

  // same-cycle flag write bypasses the status register
  assign w_flags = flag_wr ? flag_wr_data : r_status;

  assign w_peff = (flag_wr && (r_pend != 3'd0))
                ? r_pend - 3'd1
                : r_pend;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cond_eval u_eval (
      .cond      (in_cond[4*g +: 4]),
      .flags     (w_flags),
      .cond_true (w_true[g])
    );
  end

  // a flag setter in a lower lane invalidates the flags seen
  // by conditional lanes above it
  always_comb begin
    w_seen   = 1'b0;
    w_hazard = 1'b0;
    w_snew   = 4'd0;
    w_exec   = '0;
    w_replay = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane_valid[i] &&
          !cc_flagless(in_cond[4*i +: 4])) begin
        w_replay[i] = w_seen;
        if (w_peff != 3'd0) w_hazard = 1'b1;
      end
      w_exec[i] = in_lane_valid[i] & w_true[i]
                & !w_replay[i];
      if (w_exec[i] && in_s[i]) begin
        w_seen = 1'b1;
        w_snew = w_snew + 4'd1;
      end
    end
  end

  assign w_sum  = {1'b0, w_peff} + w_snew;
  assign w_room = (w_sum <= 4'(PEND_MAX));

  assign in_ready = !flush
                  & (!r_out_valid | out_ready)
                  & !w_hazard
                  & w_room;

  assign w_accept = in_valid & in_ready;
  assign w_pnext  = w_accept ? w_sum[2:0] : w_peff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'd0;
    end else if (flag_wr) begin
      r_status <= flag_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 3'd0;
    end else if (flush) begin
      r_pend <= 3'd0;
    end else begin
      r_pend <= w_pnext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_exec      <= '0;
      r_replay    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_exec      <= w_exec;
      r_replay    <= w_replay;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_exec   = r_exec;
  assign out_replay = r_replay;
  assign out_status = r_status;

endmodule

// File: tb/tb_cond_issue_gate.sv
// Random and directed checks of cond_issue_gate against a
// behavioural model of flags, scoreboard and output stage.
module tb_cond_issue_gate;

  localparam int L  = 2;
  localparam int PM = 3;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           flag_wr;
  logic [3:0]     flag_wr_data;
  logic           in_valid;
  logic           in_ready;
  logic [L-1:0]   in_lane_valid;
  logic [4*L-1:0] in_cond;
  logic [L-1:0]   in_s;
  logic           out_valid;
  logic           out_ready;
  logic [L-1:0]   out_exec;
  logic [L-1:0]   out_replay;
  logic [3:0]     out_status;

  int n_vec;
  int n_err;

  logic [3:0]   m_status;
  int           m_p;
  logic         m_ov;
  logic [L-1:0] m_ex;
  logic [L-1:0] m_rp;

  cond_issue_gate #(.LANES(L), .PEND_MAX(PM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .flag_wr       (flag_wr),
    .flag_wr_data  (flag_wr_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_lane_valid (in_lane_valid),
    .in_cond       (in_cond),
    .in_s          (in_s),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_exec      (out_exec),
    .out_replay    (out_replay),
    .out_status    (out_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ARM pairing: even code tests a base predicate, odd inverts it
  function automatic logic ref_cond(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic z, cy, n, v, b;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return !c[0];
    endcase
    return b ^ c[0];
  endfunction

  task automatic model_reset();
    m_status = 4'd0;
    m_p      = 0;
    m_ov     = 1'b0;
    m_ex     = '0;
    m_rp     = '0;
  endtask

  // drive at negedge, check #1 later, clock, update model
  task automatic step(
    input logic           fw,
    input logic [3:0]     fd,
    input logic           iv,
    input logic [L-1:0]   lv,
    input logic [4*L-1:0] cd,
    input logic [L-1:0]   s,
    input logic           ordy,
    input logic           fl
  );
    logic [3:0]   f;
    logic [L-1:0] e, r;
    logic         seen, hz, rdy;
    logic [3:0]   c;
    int           peff, snew;
    flag_wr = fw; flag_wr_data = fd; in_valid = iv;
    in_lane_valid = lv; in_cond = cd; in_s = s;
    out_ready = ordy; flush = fl;
    #1;
    f    = fw ? fd : m_status;
    peff = (fw && m_p > 0) ? m_p - 1 : m_p;
    seen = 0; hz = 0; snew = 0; e = '0; r = '0;
    for (int i = 0; i < L; i++) begin
      c = cd[4*i +: 4];
      if (lv[i] && c != 4'hE && c != 4'hF) begin
        r[i] = seen;
        if (peff > 0) hz = 1;
      end
      e[i] = lv[i] && ref_cond(c, f) && !r[i];
      if (e[i] && s[i]) begin
        seen = 1;
        snew++;
      end
    end
    rdy = !fl && (!m_ov || ordy) && !hz && (peff + snew <= PM);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_status", 32'(out_status), 32'(m_status));
    if (m_ov) begin
      chk("out_exec", 32'(out_exec), 32'(m_ex));
      chk("out_replay", 32'(out_replay), 32'(m_rp));
    end
    @(posedge clk);
    if (fw) m_status = fd;
    if (fl) begin
      m_ov = 0;
      m_p  = 0;
    end else if (iv && rdy) begin
      m_ov = 1;
      m_ex = e;
      m_rp = r;
      m_p  = peff + snew;
    end else begin
      m_p = peff;
      if (ordy) m_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 4'd0, 0, '0, '0, '0, 1, 0);
  endtask

  task automatic rnd_step();
    logic [4*L-1:0] cd;
    for (int i = 0; i < L; i++) begin
      if ($urandom_range(0, 2) == 0) cd[4*i +: 4] = 4'hE;
      else cd[4*i +: 4] = 4'($urandom_range(0, 15));
    end
    step($urandom_range(0, 2) == 0,
         4'($urandom),
         $urandom_range(0, 3) != 0,
         L'($urandom),
         cd,
         L'($urandom),
         $urandom_range(0, 3) != 0,
         $urandom_range(0, 29) == 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 0; flag_wr = 0; flag_wr_data = 0;
    in_valid = 0; in_lane_valid = 0; in_cond = 0;
    in_s = 0; out_ready = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_exec", 32'(out_exec), 32'd0);
    chk("rst_out_replay", 32'(out_replay), 32'd0);
    chk("rst_out_status", 32'(out_status), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Z set: EQ executes, NE does not
    step(1, 4'b1000, 1, 2'b11, {4'h1, 4'h0}, 2'b00, 1, 0);
    chk("t1_exec", 32'(out_exec), 32'b01);
    chk("t1_status", 32'(out_status), 32'b1000);

    // ADDS in lane0 forces EQ in lane1 to replay
    step(0, 4'd0, 1, 2'b11, {4'h0, 4'hE}, 2'b01, 1, 0);
    chk("t2_exec", 32'(out_exec), 32'b01);
    chk("t2_replay", 32'(out_replay), 32'b10);
    step(0, 4'd0, 1, 2'b01, {4'hE, 4'hC}, 2'b00, 1, 0);
    chk("t2_blocked", 32'(out_valid), 32'd0);

    // owed flag arrives with the GT group
    step(1, 4'b0000, 1, 2'b01, {4'hE, 4'hC}, 2'b00, 0, 0);
    chk("t3_exec", 32'(out_exec), 32'b01);

    // downstream stall then release
    repeat (3) step(0, 4'd0, 1, 2'b01, {4'hE, 4'hE}, 2'b00, 0, 0);
    step(0, 4'd0, 1, 2'b01, {4'hE, 4'hE}, 2'b00, 1, 0);

    // fill the scoreboard
    repeat (3) step(0, 4'd0, 1, 2'b01, {4'hE, 4'hE}, 2'b01, 1, 0);
    step(0, 4'd0, 1, 2'b01, {4'hE, 4'hE}, 2'b01, 1, 0);
    chk("t5_full", 32'(out_valid), 32'd0);
    step(1, 4'd0, 1, 2'b01, {4'hE, 4'hE}, 2'b01, 0, 0);

    // flush with a held group and owed flags
    step(0, 4'd0, 0, 2'b00, '0, '0, 0, 0);
    step(0, 4'd0, 1, 2'b01, {4'hE, 4'h0}, 2'b00, 0, 1);
    chk("t6_flush", 32'(out_valid), 32'd0);
    step(0, 4'd0, 1, 2'b01, {4'hE, 4'h0}, 2'b00, 1, 0);
    chk("t6_accept", 32'(out_valid), 32'd1);

    repeat (2000) rnd_step();

    // asynchronous reset mid-transfer
    idle();
    step(0, 4'd0, 1, 2'b01, {4'hE, 4'hE}, 2'b00, 0, 0);
    chk("ar_held", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_status", 32'(out_status), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) rnd_step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cond_issue_gate.md
# cond_issue_gate

Multi-lane condition gate with an NZCV status register and a flag-hazard scoreboard, sitting between decode and execute. Each cycle it can accept a group of up to LANES instructions and evaluate every lane's 4-bit ARM condition against the current flags, with bypass of a same-cycle flag write. It stalls when flags are still owed by in-flight flag-setting instructions and registers per-lane execute/replay decisions behind a valid/ready output stage. It replaces per-instruction combinational condition checking in multi-issue configurations.

## Interface
Parameters:
- LANES, 2, instructions per group (1..4)
- PEND_MAX, 3, max outstanding flag-setting instructions tracked (1..7)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop held output group, clear scoreboard
- flag_wr  in  1  execute stage writes flags this cycle
- flag_wr_data  in  4  new status {Z,C,N,V}
- in_valid  in  1  input group valid
- in_ready  out  1  group accepted when in_valid & in_ready
- in_lane_valid  in  LANES  lane occupied
- in_cond  in  4*LANES  lane i condition in bits [4i+3:4i]
- in_s  in  LANES  lane sets flags (S bit)
- out_valid  out  1  registered group valid
- out_ready  in  1  downstream accepts
- out_exec  out  LANES  lane executes
- out_replay  out  LANES  lane must be reissued by upstream
- out_status  out  4  architectural status register {Z,C,N,V}

## Operation
- Status register: reset 4'b0000; loads flag_wr_data when flag_wr; unaffected by flush.
- Effective flags F = flag_wr ? flag_wr_data : status.
- Conditions on F: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 (NV) 0.
- Pending counter P (3 bits): reset 0. P_eff = P - flag_wr (saturating at 0).
- Hazard: any valid lane with cond not in {AL, NV} while P_eff > 0.
- Intra-group: lane k is replayed if a lower lane j<k is valid, executes and has in_s=1, and lane k is valid with cond not in {AL, NV}; replayed lanes have out_exec=0 and do not count toward P.
- out_exec[i] = in_lane_valid[i] & cond_true & !replay[i].
- Accept: in_ready = (!out_valid | out_ready) & !hazard & (P_eff + S_new <= PEND_MAX), where S_new = count of executing lanes with in_s.
- On accept: P <= P_eff + S_new. Without accept: P <= P_eff.
- Flush: out_valid <= 0, P <= 0, and in_ready is forced to 0 in that cycle. A flag_wr in the same cycle still updates status.
- Invalid lanes: out_exec=0, out_replay=0.

## Timing
- Latency 1: the group accepted at edge t appears on out_* after t and is held until out_valid & out_ready.
- Reset values: out_valid 0, out_exec 0, out_replay 0, out_status 0, P 0.
- Flag bypass has zero cycles of latency. A group can be accepted in the same cycle that the last owed flag_wr arrives, and it is evaluated on flag_wr_data.
- in_ready is independent of in_valid. It depends combinationally on out_ready, flag_wr and the input lanes.
- Asserting reset mid-transfer discards the held group immediately.

## Structure
- Package cond_pkg: localparams for the 16 condition codes; status bit indices Z=3, C=2, N=1, V=0; LANES bounds.
- Sub-module cond_eval: combinational, takes cond[3:0] and flags[3:0] and returns true. Instantiate it LANES times.
- The top level holds the status register, pending counter, replay logic and output register.

## Test plan
- Reset, then flag_wr with 4'b1000 and a group {EQ, NE} -> out_exec=2'b01 one cycle later; out_status=4'b1000.
- Lane0 ADDS (AL, s=1) and lane1 EQ -> out_exec=2'b01, out_replay=2'b10, P=1. A following GT group -> in_ready=0 until flag_wr.
- P=1; flag_wr with 4'b0000 in the same cycle as an in_valid group {GT} -> accepted that cycle, out_exec[0]=1, P=0.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; release -> next group accepted.
- Fill P to PEND_MAX=3 with AL,s=1 groups, then offer another -> in_ready=0. One flag_wr -> accepted.
- P=2 with a held output; assert flush -> out_valid=0 and P=0 next cycle. A following EQ group is accepted immediately.
